// File: rtl/cpu_core_if.sv
// Data-memory bus between the cpu_core datapath (master) and its data memory (slave).
interface cpu_core_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/cpu_core.sv
// Single-cycle 32-bit MIPS-I-subset core with internal instruction memory,
// data memory and register file; depths are expected to be powers of two.

module cpu_imem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_data,
  input  logic [31:0]              addr,
  output logic [31:0]              rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] inst [0:DEPTH-1];
  logic        unused_addr;

  // Low word-address bits only, so fetches wrap modulo the depth.
  assign rdata       = inst[addr[AW+1:2]];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (load_en) inst[load_idx] <= load_data;
  end
endmodule

module cpu_dmem #(
  parameter int DEPTH = 256
) (
  input logic       clk,
  cpu_core_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] data [0:DEPTH-1];
  logic        unused_addr;

  assign bus.rdata   = data[bus.addr[AW+1:2]];
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  always_ff @(posedge clk) begin
    if (bus.we) data[bus.addr[AW+1:2]] <= bus.wdata;
  end
endmodule

module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

module cpu_core #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic rst
);
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU= 6'h09, OP_SLTI = 6'h0A,
    OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
    OP_LW    = 6'h23, OP_SW   = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08,
    FN_ADD = 6'h20, FN_ADDU= 6'h21, FN_SUB = 6'h22, FN_SUBU= 6'h23,
    FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
    FN_SLT = 6'h2A
  } funct_e;

  logic [31:0] pc, pc_plus4, next_pc, instr;
  logic [31:0] a, b, sext, zext, branch_tgt, wdata;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, waddr;
  logic        reg_we, mem_we;

  cpu_core_if dbus ();

  cpu_imem #(.DEPTH(IMEM_DEPTH)) inst_mem (
    .clk       (clk),
    .load_en   (1'b0),
    .load_idx  ('0),
    .load_data ('0),
    .addr      (pc),
    .rdata     (instr)
  );

  cpu_dmem #(.DEPTH(DMEM_DEPTH)) data_mem (
    .clk (clk),
    .bus (dbus.slave)
  );

  cpu_regfile reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (a),
    .rdata2 (b),
    .we     (reg_we),
    .waddr  (waddr),
    .wdata  (wdata)
  );

  assign opcode     = instr[31:26];
  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign rd         = instr[15:11];
  assign shamt      = instr[10:6];
  assign funct      = instr[5:0];
  assign sext       = {{16{instr[15]}}, instr[15:0]};
  assign zext       = {16'h0000, instr[15:0]};
  assign pc_plus4   = pc + 32'd4;
  assign branch_tgt = pc_plus4 + {sext[29:0], 2'b00};

  // Stores are suppressed while reset is held so memory contents survive it.
  assign dbus.addr  = a + sext;
  assign dbus.wdata = b;
  assign dbus.we    = mem_we & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= next_pc;
  end

  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    waddr   = rt;
    wdata   = '0;
    next_pc = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        waddr  = rd;
        reg_we = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: wdata = a + b;
          FN_SUB, FN_SUBU: wdata = a - b;
          FN_AND:          wdata = a & b;
          FN_OR:           wdata = a | b;
          FN_XOR:          wdata = a ^ b;
          FN_NOR:          wdata = ~(a | b);
          FN_SLT:          wdata = {31'd0, $signed(a) < $signed(b)};
          FN_SLL:          wdata = b << shamt;
          FN_SRL:          wdata = b >> shamt;
          FN_SRA:          wdata = 32'($signed(b) >>> shamt);
          FN_JR: begin
            reg_we  = 1'b0;
            next_pc = a;
          end
          default:         reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin reg_we = 1'b1; wdata = a + sext; end
      OP_SLTI: begin reg_we = 1'b1; wdata = {31'd0, $signed(a) < $signed(sext)}; end
      OP_ANDI: begin reg_we = 1'b1; wdata = a & zext; end
      OP_ORI:  begin reg_we = 1'b1; wdata = a | zext; end
      OP_XORI: begin reg_we = 1'b1; wdata = a ^ zext; end
      OP_LUI:  begin reg_we = 1'b1; wdata = {instr[15:0], 16'h0000}; end
      OP_LW:   begin reg_we = 1'b1; wdata = dbus.rdata; end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (a == b) next_pc = branch_tgt;
      OP_BNE:  if (a != b) next_pc = branch_tgt;
      OP_J:    next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      OP_JAL: begin
        next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        reg_we  = 1'b1;
        waddr   = 5'd31;
        wdata   = pc_plus4;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_core.sv
// Directed program bench for cpu_core: expectations are queued as each program is
// set up and popped against register file, data memory and PC after it runs.
module tb_cpu_core;
  logic clk;
  logic rst;

  typedef struct {
    string       tag;
    int unsigned kind;   // 0 register, 1 data word, 2 PC
    logic [7:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned n_fail;

  cpu_core #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic expect_val(input string tag, input int unsigned kind,
                            input logic [7:0] idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = dut.reg_file.regs[e.idx[4:0]];
        1:       obs = dut.data_mem.data[e.idx];
        default: obs = dut.pc;
      endcase
      n_checks++;
      assert (obs === e.val) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s[%0d]: observed %h expected %h", e.tag, e.idx, obs, e.val);
      end
    end
  endtask

  // Asserts reset on a falling clock edge, checks PC clears at once, loads prog.
  task automatic begin_test(input string name);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_val({name, "_reset_pc"}, 2, 8'd0, 32'h0);
    check_all();
    for (int i = 0; i < 256; i++) dut.inst_mem.inst[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.inst_mem.inst[i] = prog[i];
  endtask

  task automatic run(input int unsigned n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    n_checks = 0; n_pass = 0; n_fail = 0;

    // arithmetic with wrap on sub
    prog = '{i_ins(6'h08, 5'd0, 5'd1, 16'd5), i_ins(6'h08, 5'd0, 5'd2, 16'd7),
             r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), r_ins(5'd1, 5'd2, 5'd4, 5'd0, 6'h22)};
    begin_test("arith");
    expect_val("arith_r3", 0, 8'd3, 32'd12);
    expect_val("arith_r4", 0, 8'd4, 32'hFFFF_FFFE);
    expect_val("arith_pc", 2, 8'd0, 32'd16);
    run(4);
    check_all();

    // load then store of a preloaded word
    prog = '{i_ins(6'h23, 5'd0, 5'd5, 16'd0), i_ins(6'h2B, 5'd0, 5'd5, 16'd4)};
    begin_test("mem");
    dut.data_mem.data[0] = 32'h0000_000A;
    dut.data_mem.data[1] = 32'h0;
    expect_val("mem_r5", 0, 8'd5, 32'd10);
    expect_val("mem_d1", 1, 8'd1, 32'd10);
    run(2);
    check_all();

    // countdown loop: taken bne twice, falls through on the third
    prog = '{i_ins(6'h08, 5'd0, 5'd1, 16'd3), i_ins(6'h08, 5'd1, 5'd1, 16'hFFFF),
             i_ins(6'h05, 5'd1, 5'd0, 16'hFFFE)};
    begin_test("loop");
    expect_val("loop_pc_taken", 2, 8'd0, 32'd4);
    expect_val("loop_r1_mid", 0, 8'd1, 32'd2);
    run(3);
    check_all();
    expect_val("loop_r1", 0, 8'd1, 32'd0);
    expect_val("loop_pc_exit", 2, 8'd0, 32'd12);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_all();

    // $0 stays zero; lui/ori build a constant
    prog = '{i_ins(6'h08, 5'd0, 5'd0, 16'd9), i_ins(6'h0F, 5'd0, 5'd6, 16'h1234),
             i_ins(6'h0D, 5'd6, 5'd6, 16'h5678)};
    begin_test("lui");
    expect_val("lui_r0", 0, 8'd0, 32'd0);
    expect_val("lui_r6", 0, 8'd6, 32'h1234_5678);
    run(3);
    check_all();

    // jal to word 16, then jr back to the return address
    prog = '{j_ins(6'h03, 26'h10)};
    begin_test("jal");
    dut.inst_mem.inst[16] = r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
    expect_val("jal_r31", 0, 8'd31, 32'd4);
    expect_val("jal_pc", 2, 8'd0, 32'h40);
    run(1);
    check_all();
    expect_val("jr_pc", 2, 8'd0, 32'd4);
    @(posedge clk);
    @(negedge clk);
    check_all();

    // logic, shifts, signed compares, zero-extension, nop opcode, beq both ways
    prog = '{i_ins(6'h08, 5'd0, 5'd1, 16'hFFF8),      // r1 = -8
             i_ins(6'h08, 5'd0, 5'd2, 16'd3),         // r2 = 3
             r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A),    // slt
             r_ins(5'd0, 5'd1, 5'd4, 5'd1, 6'h03),    // sra
             r_ins(5'd0, 5'd1, 5'd5, 5'd28, 6'h02),   // srl
             r_ins(5'd0, 5'd2, 5'd6, 5'd4, 6'h00),    // sll
             r_ins(5'd0, 5'd0, 5'd7, 5'd0, 6'h27),    // nor
             i_ins(6'h0C, 5'd1, 5'd8, 16'hFFFF),      // andi
             i_ins(6'h0A, 5'd2, 5'd9, 16'hFFFF),      // slti 3 < -1
             r_ins(5'd1, 5'd2, 5'd10, 5'd0, 6'h26),   // xor
             r_ins(5'd7, 5'd2, 5'd11, 5'd0, 6'h21),   // addu wraps
             i_ins(6'h3F, 5'd0, 5'd12, 16'h1234),     // unlisted opcode
             i_ins(6'h04, 5'd1, 5'd2, 16'd5),         // beq not taken
             i_ins(6'h04, 5'd2, 5'd2, 16'd1),         // beq taken, skips next
             i_ins(6'h08, 5'd0, 5'd13, 16'd1),
             i_ins(6'h0A, 5'd1, 5'd14, 16'hFFFF)};    // slti -8 < -1
    begin_test("alu");
    expect_val("alu_slt", 0, 8'd3, 32'd1);
    expect_val("alu_sra", 0, 8'd4, 32'hFFFF_FFFC);
    expect_val("alu_srl", 0, 8'd5, 32'h0000_000F);
    expect_val("alu_sll", 0, 8'd6, 32'h0000_0030);
    expect_val("alu_nor", 0, 8'd7, 32'hFFFF_FFFF);
    expect_val("alu_andi", 0, 8'd8, 32'h0000_FFF8);
    expect_val("alu_slti0", 0, 8'd9, 32'd0);
    expect_val("alu_xor", 0, 8'd10, 32'hFFFF_FFFB);
    expect_val("alu_addu", 0, 8'd11, 32'd2);
    expect_val("alu_nop", 0, 8'd12, 32'd0);
    expect_val("alu_skip", 0, 8'd13, 32'd0);
    expect_val("alu_slti1", 0, 8'd14, 32'd1);
    expect_val("alu_pc", 2, 8'd0, 32'd64);
    run(15);
    check_all();

    // reset held and reset mid-run: no stores, state clears, memory survives
    prog = '{i_ins(6'h2B, 5'd0, 5'd1, 16'd12), i_ins(6'h08, 5'd0, 5'd1, 16'd5),
             i_ins(6'h08, 5'd0, 5'd2, 16'd7), r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20)};
    begin_test("rst");
    dut.data_mem.data[3] = 32'h55;
    dut.data_mem.data[5] = 32'h77;
    expect_val("rst_no_store", 1, 8'd3, 32'h55);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    expect_val("rst_run_d3", 1, 8'd3, 32'h0);
    expect_val("rst_run_r1", 0, 8'd1, 32'd5);
    expect_val("rst_run_r2", 0, 8'd2, 32'd7);
    expect_val("rst_run_pc", 2, 8'd0, 32'd12);
    run(3);
    check_all();
    rst = 1'b0;
    #1;
    expect_val("midrst_pc", 2, 8'd0, 32'd0);
    for (int i = 1; i < 32; i++) expect_val("midrst_reg", 0, 8'(i), 32'd0);
    expect_val("midrst_d5", 1, 8'd5, 32'h77);
    check_all();
    @(posedge clk);
    @(negedge clk);
    expect_val("restart_r3", 0, 8'd3, 32'd12);
    expect_val("restart_pc", 2, 8'd0, 32'd16);
    run(4);
    check_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter IMEM_DEPTH, default 256: number of 32-bit words in the internal instruction memory.
REQ-002 Parameter DMEM_DEPTH, default 256: number of 32-bit words in the internal data memory.
REQ-003 Port clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 No other ports; all observation is through hierarchical paths.
- inst_mem.inst[0:IMEM_DEPTH-1]: instruction memory.
- data_mem.data[0:DMEM_DEPTH-1]: data memory.
- reg_file.regs[0:31]: register file.
- All three are 32-bit arrays, loadable by $readmemh.

Function
REQ-006 Architecture: single-cycle, 32-bit, MIPS-I-style encoding; one instruction completes per clk rising edge.
REQ-007 Instruction fetch is combinational: inst_mem.inst[PC[9:2]] (word-indexed).
REQ-008 Data memory is word-indexed by ALU result bits [9:2].
- Read is combinational.
- Write occurs on the clk rising edge.
REQ-009 Register file: 32x32 with two combinational read ports and one write port written on the rising edge.
- regs[0] always reads 0.
- Writes to regs[0] are ignored.
REQ-010 Supported R-type instructions (opcode 0x00, by funct):
- add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A: write rd.
- sll 0x00, srl 0x02, sra 0x03: shift rt by shamt, write rd.
- jr 0x08: PC <= rs.
REQ-011 Supported I-type instructions (by opcode):
- addi 0x08, addiu 0x09, slti 0x0A: imm sign-extended; result written to rt.
- andi 0x0C, ori 0x0D, xori 0x0E: imm zero-extended; result written to rt.
- lui 0x0F: rt <= {imm,16'h0}.
- lw 0x23: rt <= data[rs+sext(imm)].
- sw 0x2B: data[rs+sext(imm)] <= rt.
- beq 0x04, bne 0x05: PC <= PC+4+(sext(imm)<<2) when the condition holds, else PC+4.
REQ-012 J-type instructions:
- j 0x02: PC <= {PC+4[31:28], target, 2'b00}.
- jal 0x03: same target as j; regs[31] <= PC+4.
REQ-013 Default next PC is PC+4 with 32-bit wrap-around; no overflow traps (add/sub wrap modulo 2^32).
REQ-014 slt/slti perform a signed compare and produce 1 or 0.
REQ-015 Any unlisted opcode or funct executes as a NOP: no register or memory write, PC+4.
REQ-016 Fetch addresses beyond IMEM_DEPTH wrap modulo the depth (index uses the low address bits only); the same rule applies to data memory.
REQ-017 There are no hazards and no delay slots: a branch or jump takes effect on the next edge.

Reset
REQ-018 While rst is low:
- PC is forced to 0 immediately (asynchronous).
- All reg_file.regs are cleared to 0.
- No memory writes occur.
REQ-019 Reset does not clear inst_mem or data_mem; preloaded contents survive reset.
REQ-020 Deasserting rst releases execution: the first rising edge after rst goes high executes inst[0].
REQ-021 Asserting rst mid-program aborts the in-flight instruction (no write that edge) and returns PC to 0.

Verification
REQ-022 Program: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sub $4,$1,$2 -> after 4 cycles regs[3]=12, regs[4]=0xFFFFFFFE.
REQ-023 data[0]=0x0000000A preloaded; lw $5,0($0); sw $5,4($0) -> regs[5]=10, data[1]=10.
REQ-024 addi $1,$0,3; loop: addi $1,$1,-1; bne $1,$0,loop -> regs[1]=0, PC exits the loop after 7 instructions.
REQ-025 addi $0,$0,9 -> regs[0] reads 0; lui $6,0x1234 then ori $6,$6,0x5678 -> regs[6]=0x12345678.
REQ-026 jal 0x10 at PC 0 -> regs[31]=4 and PC=0x40; jr $31 -> PC=4.
REQ-027 Pull rst low mid-run for one cycle -> PC=0 and all regs=0 immediately; data_mem unchanged; execution restarts at inst[0].
